// File: rtl/pc_pkg.sv
// Shared types and default sizing for the PC sequencer.
package pc_pkg;

  typedef enum logic [2:0] {
    NEXT   = 3'd0,
    BR_REL = 3'd1,
    BR_ABS = 3'd2,
    CALL   = 3'd3,
    RET    = 3'd4,
    HALT   = 3'd5
  } pc_op_t;

  localparam int PC_W_DEF        = 10;
  localparam int LUT_IDX_W_DEF   = 3;
  localparam int STACK_DEPTH_DEF = 4;

endpackage

// File: rtl/pc_target_lut.sv
// Branch-target register file: one combinational read, one synchronous write.
// Contents are deliberately not reset so targets survive a sequencer re-init.
module pc_target_lut #(
  parameter int PC_W      = 10,
  parameter int LUT_IDX_W = 3
) (
  input  logic                 CLK,
  input  logic [LUT_IDX_W-1:0] ridx,
  output logic [PC_W-1:0]      rdata,
  input  logic                 we,
  input  logic [LUT_IDX_W-1:0] widx,
  input  logic [PC_W-1:0]      wdata
);

  logic [PC_W-1:0] mem [2**LUT_IDX_W];

  // A read of the index being written this cycle sees the old entry.
  assign rdata = mem[ridx];

  // Write port, independent of stall/halt.
  always_ff @(posedge CLK) begin
    if (we) mem[widx] <= wdata;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter / fetch sequencer with target LUT, return stack, stall,
// explicit HALT and an end-of-program limit.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              PC_W        = PC_W_DEF,
  parameter int              LUT_IDX_W   = LUT_IDX_W_DEF,
  parameter int              STACK_DEPTH = STACK_DEPTH_DEF,
  parameter logic [PC_W-1:0] PROG_LAST   = PC_W'(2**PC_W - 1)
) (
  input  logic                 CLK,
  input  logic                 init,
  input  logic                 stall,
  input  logic [2:0]           op,
  input  logic                 cond,
  input  logic [LUT_IDX_W-1:0] lut_idx,
  input  logic                 lut_we,
  input  logic [LUT_IDX_W-1:0] lut_widx,
  input  logic [PC_W-1:0]      lut_wdata,
  output logic [PC_W-1:0]      PC,
  output logic                 halt,
  output logic                 stack_err
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PC_W-1:0]  tgt;
  logic [PC_W-1:0]  stk [STACK_DEPTH];
  logic [SP_W-1:0]  sp, sp_nxt;
  logic [PC_W-1:0]  pc_nxt, pc_inc;
  logic             halt_nxt, err_nxt, push, seq;
  logic [IDX_W-1:0] push_idx, pop_idx;

  pc_target_lut #(.PC_W(PC_W), .LUT_IDX_W(LUT_IDX_W)) u_lut (
    .CLK   (CLK),
    .ridx  (lut_idx),
    .rdata (tgt),
    .we    (lut_we),
    .widx  (lut_widx),
    .wdata (lut_wdata)
  );

  assign pc_inc   = PC + PC_W'(1);
  assign push_idx = IDX_W'(sp);
  assign pop_idx  = IDX_W'(sp - SP_W'(1));

  // Next-state decode; "seq" marks a sequential advance so the end limit
  // is applied in one place.
  always_comb begin
    pc_nxt   = PC;
    sp_nxt   = sp;
    halt_nxt = halt;
    err_nxt  = stack_err;
    push     = 1'b0;
    seq      = 1'b0;
    if (!halt && !stall) begin
      case (op)
        BR_REL: if (cond) pc_nxt = PC + tgt; else seq = 1'b1;
        BR_ABS: if (cond) pc_nxt = tgt;      else seq = 1'b1;
        CALL: begin
          if (sp == SP_W'(STACK_DEPTH)) begin
            err_nxt  = 1'b1;
            halt_nxt = 1'b1;
          end else begin
            push   = 1'b1;
            pc_nxt = tgt;
            sp_nxt = sp + SP_W'(1);
          end
        end
        RET: begin
          if (sp == '0) begin
            err_nxt  = 1'b1;
            halt_nxt = 1'b1;
          end else begin
            pc_nxt = stk[pop_idx];
            sp_nxt = sp - SP_W'(1);
          end
        end
        HALT:    halt_nxt = 1'b1;
        default: seq = 1'b1;  // NEXT and unused encodings
      endcase
      if (seq) begin
        if (PC == PROG_LAST) halt_nxt = 1'b1;
        else                 pc_nxt   = pc_inc;
      end
    end
  end

  // PC, stack pointer and sticky flags; init dominates.
  always_ff @(posedge CLK) begin
    if (init) begin
      PC        <= '0;
      sp        <= '0;
      halt      <= 1'b0;
      stack_err <= 1'b0;
    end else begin
      PC        <= pc_nxt;
      sp        <= sp_nxt;
      halt      <= halt_nxt;
      stack_err <= err_nxt;
    end
  end

  // Return-address storage; the return address wraps naturally at the top.
  always_ff @(posedge CLK) begin
    if (!init && push) stk[push_idx] <= pc_inc;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer (PROG_LAST=20, STACK_DEPTH=4).
module tb_pc_sequencer;
  import pc_pkg::*;

  logic       CLK = 1'b0;
  logic       init = 1'b1, stall = 1'b0, cond = 1'b0, lut_we = 1'b0;
  logic [2:0] op = 3'd0, lut_idx = 3'd0, lut_widx = 3'd0;
  logic [9:0] lut_wdata = 10'd0;
  logic [9:0] PC;
  logic       halt, stack_err;

  typedef struct {
    logic [9:0] pc;
    logic       h;
    logic       e;
    string      nm;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  pc_sequencer #(.PC_W(10), .LUT_IDX_W(3), .STACK_DEPTH(4), .PROG_LAST(10'd20)) dut (
    .CLK(CLK), .init(init), .stall(stall), .op(op), .cond(cond), .lut_idx(lut_idx),
    .lut_we(lut_we), .lut_widx(lut_widx), .lut_wdata(lut_wdata),
    .PC(PC), .halt(halt), .stack_err(stack_err)
  );

  always #5 CLK = ~CLK;

  // Monitor: outputs are presented every cycle; compare against queued expectation.
  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (PC !== e.pc || halt !== e.h || stack_err !== e.e) begin
        errors++;
        $display("FAIL %s: got PC=%0d halt=%b err=%b, expected PC=%0d halt=%b err=%b",
                 e.nm, PC, halt, stack_err, e.pc, e.h, e.e);
      end
    end
  end

  // One clock of stimulus; expectation pushed after the edge it applies to.
  task automatic step(input bit ini, input bit stl, input logic [2:0] o, input bit c,
                      input logic [2:0] idx, input bit we, input logic [2:0] wi,
                      input logic [9:0] wd, input logic [9:0] epc, input bit eh,
                      input bit ee, input string nm);
    exp_t e;
    init = ini; stall = stl; op = o; cond = c; lut_idx = idx;
    lut_we = we; lut_widx = wi; lut_wdata = wd;
    @(posedge CLK);
    e.pc = epc; e.h = eh; e.e = ee; e.nm = nm;
    q.push_back(e);
    @(negedge CLK);
  endtask

  task automatic nxt(input logic [9:0] epc, input bit eh, input bit ee, input string nm);
    step(0, 0, NEXT, 0, 0, 0, 0, 0, epc, eh, ee, nm);
  endtask

  task automatic ini_w(input logic [2:0] wi, input logic [9:0] wd);
    step(1, 0, NEXT, 0, 0, 1, wi, wd, 10'd0, 0, 0, "init");
  endtask

  initial begin
    @(negedge CLK);
    // 1: reset and sequential advance
    step(1, 0, NEXT, 0, 0, 0, 0, 0, 10'd0, 0, 0, "reset");
    for (int i = 1; i <= 5; i++) nxt(10'(i), 0, 0, "next_seq");

    // 2: relative branches, taken/untaken, and negative wrap from 0
    ini_w(3'd2, 10'h3FD);
    for (int i = 1; i <= 8; i++) nxt(10'(i), 0, 0, "next_to8");
    step(0, 0, BR_REL, 1, 3'd2, 0, 0, 0, 10'd5, 0, 0, "brrel_taken");
    for (int i = 6; i <= 8; i++) nxt(10'(i), 0, 0, "next_to8b");
    step(0, 0, BR_REL, 0, 3'd2, 0, 0, 0, 10'd9, 0, 0, "brrel_untaken");
    step(1, 0, NEXT, 0, 0, 0, 0, 0, 10'd0, 0, 0, "init2");
    step(0, 0, BR_REL, 1, 3'd2, 0, 0, 0, 10'h3FD, 0, 0, "brrel_wrap");

    // 3: call/return and underflow
    ini_w(3'd1, 10'd40);
    for (int i = 1; i <= 3; i++) nxt(10'(i), 0, 0, "next_to3");
    step(0, 0, CALL, 0, 3'd1, 0, 0, 0, 10'd40, 0, 0, "call");
    step(0, 0, RET, 0, 0, 0, 0, 0, 10'd4, 0, 0, "ret");
    step(0, 0, RET, 0, 0, 0, 0, 0, 10'd4, 1, 1, "ret_underflow");
    nxt(10'd4, 1, 1, "halted_frozen");

    // 4: overflow on 5th nested call
    ini_w(3'd3, 10'd100);
    for (int i = 0; i < 4; i++) step(0, 0, CALL, 0, 3'd3, 0, 0, 0, 10'd100, 0, 0, "call_nest");
    step(0, 0, CALL, 0, 3'd3, 0, 0, 0, 10'd100, 1, 1, "call_overflow");

    // 5: end-of-program limit
    ini_w(3'd4, 10'd18);
    step(0, 0, BR_ABS, 1, 3'd4, 1, 3'd5, 10'd5, 10'd18, 0, 0, "brabs_taken");
    nxt(10'd19, 0, 0, "next19");
    nxt(10'd20, 0, 0, "next20");
    nxt(10'd20, 1, 0, "limit_halt");
    step(0, 0, BR_ABS, 1, 3'd4, 0, 0, 0, 10'd20, 1, 0, "limit_ignored");
    step(1, 0, NEXT, 0, 0, 0, 0, 0, 10'd0, 0, 0, "limit_init");
    step(0, 0, BR_ABS, 1, 3'd4, 0, 0, 0, 10'd18, 0, 0, "brabs18");
    nxt(10'd19, 0, 0, "next19b");
    nxt(10'd20, 0, 0, "next20b");
    step(0, 0, BR_ABS, 1, 3'd5, 0, 0, 0, 10'd5, 0, 0, "taken_from_last");
    step(0, 0, BR_ABS, 1, 3'd4, 0, 0, 0, 10'd18, 0, 0, "brabs18c");
    nxt(10'd19, 0, 0, "next19c");
    nxt(10'd20, 0, 0, "next20c");
    step(0, 0, CALL, 0, 3'd5, 0, 0, 0, 10'd5, 0, 0, "call_from_last");
    step(0, 0, RET, 0, 0, 0, 0, 0, 10'd21, 0, 0, "ret_past_last");
    step(1, 0, NEXT, 0, 0, 0, 0, 0, 10'd0, 0, 0, "init5");
    step(0, 0, BR_ABS, 1, 3'd4, 0, 0, 0, 10'd18, 0, 0, "brabs18d");
    nxt(10'd19, 0, 0, "next19d");
    nxt(10'd20, 0, 0, "next20d");
    step(0, 0, BR_REL, 0, 3'd2, 0, 0, 0, 10'd20, 1, 0, "untaken_at_last");

    // 6: stall, LUT write-vs-read ordering, unknown op, HALT op
    ini_w(3'd0, 10'd30);
    nxt(10'd1, 0, 0, "next1");
    step(0, 1, BR_ABS, 1, 3'd0, 1, 3'd6, 10'd7, 10'd1, 0, 0, "stall_brabs");
    step(0, 1, HALT, 0, 0, 0, 0, 0, 10'd1, 0, 0, "stall_halt");
    step(0, 1, CALL, 0, 3'd0, 0, 0, 0, 10'd1, 0, 0, "stall_call");
    step(0, 0, RET, 0, 0, 0, 0, 0, 10'd1, 1, 1, "sp_held_underflow");
    step(1, 0, NEXT, 0, 0, 0, 0, 0, 10'd0, 0, 0, "init6");
    step(0, 0, BR_ABS, 1, 3'd0, 1, 3'd0, 10'd50, 10'd30, 0, 0, "lut_old_read");
    step(0, 0, BR_ABS, 1, 3'd0, 0, 0, 0, 10'd50, 0, 0, "lut_new_read");
    step(0, 0, BR_ABS, 1, 3'd6, 0, 0, 0, 10'd7, 0, 0, "lut_write_in_stall");
    step(0, 0, 3'd7, 1, 3'd0, 0, 0, 0, 10'd8, 0, 0, "unknown_op");
    step(0, 0, HALT, 0, 0, 0, 0, 0, 10'd8, 1, 0, "halt_op");
    step(0, 0, NEXT, 0, 0, 1, 3'd0, 10'd60, 10'd8, 1, 0, "halted_lut_write");
    step(1, 0, NEXT, 0, 0, 0, 0, 0, 10'd0, 0, 0, "init7");
    step(0, 0, BR_ABS, 1, 3'd0, 0, 0, 0, 10'd60, 0, 0, "halted_write_landed");

    repeat (3) @(negedge CLK);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
